// File: rtl/game_pkg.sv
// Shared types and helpers for the game pacing sequencer.
package game_pkg;

  localparam int LEVEL_W   = 3;
  localparam int LEVEL_MAX = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    LEVELUP = 2'b10,
    OVER    = 2'b11
  } speed_state_t;

  // Levels above LEVEL_MAX come from a tracker that overshoots; treat them as the top level.
  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] lvl);
    return (lvl > LEVEL_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX) : lvl;
  endfunction

endpackage

// File: rtl/game_speed_ctrl_tick_divider.sv
// Programmable divider: counts while run_i, emits a registered one-cycle tick
// when the count reaches period_i-1, and clears on clear_i.
module tick_divider #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      if (cnt_q == period_i - CNT_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state updates use <= so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/game_speed_ctrl.sv
// Game pacing sequencer: run/level-up/game-over FSM, level tracking, pause counter.
// Define GAME_SPEED_FLASH_EN to make flash toggle on each frame during the level-up pause.
module game_speed_ctrl #(
  parameter int CNT_W        = 16,
  parameter int BASE_PERIOD  = 8,
  parameter int STEP         = 1,
  parameter int MIN_PERIOD   = 2,
  parameter int PAUSE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       enable,
  input  logic       collision,
  input  logic [2:0] level,
  input  logic       frame,
  output logic       scroll_tick,
  output logic       score_en,
  output logic       level_up,
  output logic       flash,
  output logic [1:0] state
);

  import game_pkg::*;

  localparam int PW  = CNT_W + 4;
  localparam int PCW = $clog2(PAUSE_FRAMES + 1);

  speed_state_t       state_q, state_d;
  logic [LEVEL_W-1:0] lvl_q, lvl_d, lvl_in;
  logic [PCW-1:0]     pause_q, pause_d;
  logic               level_up_q, level_up_d;
  logic               div_clear, div_run;
  logic signed [PW-1:0] period_s;
  logic [CNT_W-1:0]   period;

  // Signed arithmetic lets a large level*STEP go negative and still clamp to the floor.
  always_comb begin
    period_s = PW'(BASE_PERIOD) - $signed({{(PW-LEVEL_W){1'b0}}, lvl_q}) * PW'(STEP);
    period   = (period_s < PW'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_s[CNT_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    pause_d    = pause_q;
    level_up_d = 1'b0;
    div_clear  = 1'b0;
    div_run    = 1'b0;
    lvl_in     = clamp_level(level);
    if (enable) begin
      // Outside RUN the divider is parked at zero, so every entry into RUN starts a fresh period.
      div_clear = (state_q != RUN);
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_d = RUN;
            lvl_d   = lvl_in;
          end
        end
        RUN: begin
          if (collision) begin
            state_d = OVER;
          end else if (lvl_in > lvl_q) begin
            state_d    = LEVELUP;
            lvl_d      = lvl_in;
            pause_d    = PCW'(PAUSE_FRAMES);
            level_up_d = 1'b1;
            div_clear  = 1'b1;
          end else begin
            lvl_d   = lvl_in;
            div_run = 1'b1;
          end
        end
        LEVELUP: begin
          if (collision) begin
            state_d = OVER;
          end else if (frame) begin
            pause_d = pause_q - PCW'(1);
            if (pause_q == PCW'(1)) state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lvl_q      <= '0;
      pause_q    <= '0;
      level_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      pause_q    <= pause_d;
      level_up_q <= level_up_d;
    end
  end

  tick_divider #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (div_clear),
    .run_i    (div_run),
    .period_i (period),
    .tick_o   (scroll_tick)
  );

`ifdef GAME_SPEED_FLASH_EN
  logic flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    if (enable) begin
      if (state_d != LEVELUP) flash_d = 1'b0;
      else if (state_q == LEVELUP && frame) flash_d = ~flash_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flash_q <= 1'b0;
    else       flash_q <= flash_d;
  end

  assign flash = flash_q;
`else
  assign flash = (state_q == LEVELUP);
`endif

  // Decoded from the state register, so these hold along with the state while enable is low.
  assign score_en = (state_q == RUN);
  assign level_up = level_up_q;
  assign state    = state_q;

endmodule

// File: tb/tb_game_speed_ctrl.sv
// Self-checking bench for game_speed_ctrl: directed vector table, corner sequences,
// and a randomized run against a behavioural model (two instances, STEP=1 and STEP=2).
module tb_game_speed_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, enable, collision, frame;
  logic [2:0] level;
  logic       tick1, sc1, lu1, fl1;
  logic [1:0] st1;
  logic       tick2, sc2, lu2, fl2;
  logic [1:0] st2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_speed_ctrl #(.CNT_W(16), .BASE_PERIOD(8), .STEP(1), .MIN_PERIOD(2), .PAUSE_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .collision(collision),
    .level(level), .frame(frame), .scroll_tick(tick1), .score_en(sc1), .level_up(lu1),
    .flash(fl1), .state(st1)
  );

  game_speed_ctrl #(.CNT_W(16), .BASE_PERIOD(8), .STEP(2), .MIN_PERIOD(2), .PAUSE_FRAMES(3)) dut2 (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .collision(collision),
    .level(level), .frame(frame), .scroll_tick(tick2), .score_en(sc2), .level_up(lu2),
    .flash(fl2), .state(st2)
  );

  typedef struct {
    logic       s, c, f, e;
    logic [2:0] lv;
    logic [1:0] e_state;
    logic       e_tick, e_score, e_lu;
  } vec_t;

  vec_t vq[$];

  // Behavioural model: elapsed clocks since the divider restarted, frames left in the pause.
  typedef struct {
    int st;
    int lvl;
    int el;
    int left;
    bit tick;
    bit lu;
    bit fl;
  } mdl_t;

  mdl_t m1, m2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic c, input logic f, input logic e,
                     input logic [2:0] lv, input logic [1:0] es, input logic et,
                     input logic esc, input logic elu);
    vec_t v;
    v.s = s; v.c = c; v.f = f; v.e = e; v.lv = lv;
    v.e_state = es; v.e_tick = et; v.e_score = esc; v.e_lu = elu;
    vq.push_back(v);
  endtask

  task automatic quiet(input logic [2:0] lv, input int n);
    for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, 1'b1, lv, RUN, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; collision = 1'b0; frame = 1'b0; enable = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    level = 3'd0;
    step();
    reset = 1'b0;
  endtask

  function automatic mdl_t mstep(mdl_t m, int stp, bit s, bit c, bit f, bit e, int lv);
    mdl_t n;
    int   nl;
    int   per;
    n = m;
    n.tick = 1'b0;
    n.lu   = 1'b0;
    if (!e) return n;
    nl  = (lv > 5) ? 5 : lv;
    per = 8 - m.lvl * stp;
    if (per < 2) per = 2;
    case (m.st)
      0, 3: if (s) begin n.st = 1; n.lvl = nl; n.el = 0; end
      1: begin
        if (c) n.st = 3;
        else if (nl > m.lvl) begin
          n.st = 2; n.lvl = nl; n.el = 0; n.left = 3; n.lu = 1'b1;
        end else begin
          n.lvl = nl;
          n.el  = m.el + 1;
          if (n.el == per) begin n.tick = 1'b1; n.el = 0; end
        end
      end
      default: begin
        if (c) n.st = 3;
        else if (f) begin
          n.left = m.left - 1;
          if (n.left == 0) begin n.st = 1; n.el = 0; end
        end
      end
    endcase
`ifdef GAME_SPEED_FLASH_EN
    if (n.st != 2) n.fl = 1'b0;
    else if (m.st == 2 && f) n.fl = !m.fl;
`else
    n.fl = (n.st == 2);
`endif
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    reset = 1'b1; level = 3'd0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset state",  st1,  2'b00);
    check("reset tick",   tick1, 1'b0);
    check("reset score",  sc1,  1'b0);
    check("reset lvlup",  lu1,  1'b0);
    check("reset flash",  fl1,  1'b0);
    check("reset state2", st2,  2'b00);
    reset = 1'b0;

    // Directed table: STEP=1 instance, BASE=8, MIN=2, PAUSE=3.
    add(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, RUN, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      quiet(3'd0, 7);
      add(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, RUN, 1'b1, 1'b1, 1'b0);
    end
    quiet(3'd0, 3);
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, LEVELUP, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, LEVELUP, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, LEVELUP, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, LEVELUP, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, RUN,     1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      quiet(3'd1, 6);
      add(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, RUN, 1'b1, 1'b1, 1'b0);
    end
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, LEVELUP, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, LEVELUP, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, OVER,    1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, OVER, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, RUN, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, RUN, 1'b0, 1'b1, 1'b0);
    quiet(3'd2, 4);
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, RUN, 1'b1, 1'b1, 1'b0);
    quiet(3'd0, 7);
    add(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, RUN, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].s; collision = vq[i].c; frame = vq[i].f; enable = vq[i].e; level = vq[i].lv;
      step();
      check($sformatf("vec%0d state", i), st1,  vq[i].e_state);
      check($sformatf("vec%0d tick", i),  tick1, vq[i].e_tick);
      check($sformatf("vec%0d score", i), sc1,  vq[i].e_score);
      check($sformatf("vec%0d lvlup", i), lu1,  vq[i].e_lu);
    end
    idle_inputs();

    // Collision and level rise together: game over without a level_up pulse.
    level = 3'd3; collision = 1'b1;
    step();
    check("coll+rise state", st1, OVER);
    check("coll+rise lvlup", lu1, 1'b0);
    check("coll+rise score", sc1, 1'b0);
    idle_inputs();

    // Collision on the frame that would end the pause.
    level = 3'd0; start = 1'b1; step(); start = 1'b0;
    step(); step();
    level = 3'd1; step();
    check("pause entry state", st1, LEVELUP);
    check("pause entry lvlup", lu1, 1'b1);
    frame = 1'b1; step(); step();
    collision = 1'b1; step();
    check("coll+expiry state", st1, OVER);
    check("coll+expiry score", sc1, 1'b0);
    idle_inputs();

    // Enable low at cnt=4 freezes everything, even with other inputs active.
    level = 3'd0; start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    enable = 1'b0; frame = 1'b1; start = 1'b1; collision = 1'b1; level = 3'd5;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("frozen%0d tick", k),  tick1, 1'b0);
      check($sformatf("frozen%0d state", k), st1, RUN);
      check($sformatf("frozen%0d lvlup", k), lu1, 1'b0);
    end
    idle_inputs(); level = 3'd0;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (tick1 === 1'b1 && first == 0) first = k;
    end
    check("resume tick delay", first, 4);

    // Level 7 clamps to 5: period 3 at STEP=1, floor of 2 at STEP=2.
    do_reset();
    level = 3'd7; start = 1'b1; step(); start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("lvl7 step1 edge%0d", e), tick1, (e % 3 == 0));
      check($sformatf("lvl7 step2 edge%0d", e), tick2, (e % 2 == 0));
    end
    check("lvl7 no levelup", st1, RUN);

    // Asynchronous reset in the middle of a level-up pause with flash high.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    step();
    level = 3'd1; step();
    frame = 1'b1; step(); frame = 1'b0;
    check("pre-reset state", st1, LEVELUP);
    check("pre-reset flash", fl1, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("async rst state",  st1,  2'b00);
    check("async rst tick",   tick1, 1'b0);
    check("async rst score",  sc1,  1'b0);
    check("async rst lvlup",  lu1,  1'b0);
    check("async rst flash",  fl1,  1'b0);
    check("async rst state2", st2,  2'b00);
    check("async rst flash2", fl2,  1'b0);
    #2 reset = 1'b0;

    // Randomized run against the model.
    do_reset();
    m1 = '{default: 0};
    m2 = '{default: 0};
    for (int n = 0; n < 3000; n++) begin
      start     = ($urandom_range(0, 15) == 0);
      collision = ($urandom_range(0, 39) == 0);
      frame     = ($urandom_range(0, 3) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) level = 3'($urandom_range(0, 7));
      m1 = mstep(m1, 1, start, collision, frame, enable, int'(level));
      m2 = mstep(m2, 2, start, collision, frame, enable, int'(level));
      step();
      check($sformatf("rnd%0d state", n),  st1,  m1.st[1:0]);
      check($sformatf("rnd%0d tick", n),   tick1, m1.tick);
      check($sformatf("rnd%0d score", n),  sc1,  (m1.st == 1));
      check($sformatf("rnd%0d lvlup", n),  lu1,  m1.lu);
      check($sformatf("rnd%0d flash", n),  fl1,  m1.fl);
      check($sformatf("rnd%0d state2", n), st2,  m2.st[1:0]);
      check($sformatf("rnd%0d tick2", n),  tick2, m2.tick);
      check($sformatf("rnd%0d score2", n), sc2,  (m2.st == 1));
      check($sformatf("rnd%0d lvlup2", n), lu2,  m2.lu);
      check($sformatf("rnd%0d flash2", n), fl2,  m2.fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
